square_wave_gen: RTL and testbench

Programmable square-wave (clock-divider style) generator. Drives a single registered output that is high for `rise` clock cycles and then low for `fall` clock cycles, repeating indefinitely. The block is a standalone leaf in the digital-clock blocks, used to derive slow or asymmetric timing waveforms from the system clock. High/low durations are run-time inputs, sampled once per period so that changes never produce truncated or glitched phases.

---
 rtl/square_wave_gen_if.sv | 21 ++
 rtl/square_wave_gen.sv | 72 +++++++
 tb/tb_square_wave_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/square_wave_gen_if.sv
// square_wave_gen_if: duration inputs and waveform output
// of the programmable square-wave generator.
interface square_wave_gen_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             clk_out;

  modport master (
    output rise,
    output fall,
    input  clk_out
  );

  modport slave (
    input  rise,
    input  fall,
    output clk_out
  );
endinterface

// File: rtl/square_wave_gen.sv
// square_wave_gen: registered output high for rise cycles,
// low for fall cycles; durations sampled once per period.
module square_wave_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  square_wave_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] f_q;
  logic             out_q;
  logic             start_d;

  // The rise duration needs no shadow copy: it goes
  // straight into the counter at period start, while the
  // fall duration must survive until the high phase ends.

  // Period start: after reset, end of low phase, or end of
  // a high phase when no low phase follows.
  always_comb begin
    start_d = 1'b0;
    unique case (state_q)
      ST_RESET: start_d = 1'b1;
      ST_LOW:   start_d = (cnt_q == '0);
      ST_HIGH:  start_d = (cnt_q == '0) && (f_q == '0);
      default:  start_d = 1'b1;
    endcase
  end

  // Phase FSM with down-counter and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      f_q     <= '0;
      out_q   <= 1'b0;
    end else if (start_d) begin
      f_q <= bus.fall;
      if (bus.rise != '0) begin
        state_q <= ST_HIGH;
        cnt_q   <= bus.rise - WIDTH'(1);
        out_q   <= 1'b1;
      end else if (bus.fall != '0) begin
        state_q <= ST_LOW;
        cnt_q   <= bus.fall - WIDTH'(1);
        out_q   <= 1'b0;
      end else begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end
    end else if (state_q == ST_HIGH && cnt_q == '0) begin
      state_q <= ST_LOW;
      cnt_q   <= f_q - WIDTH'(1);
      out_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign bus.clk_out = out_q;

endmodule

// File: tb/tb_square_wave_gen.sv
// tb_square_wave_gen: randomized and directed checks against
// a queue-based waveform model of square_wave_gen.
module tb_square_wave_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass = 0;
  int   total = 0;

  square_wave_gen_if #(.WIDTH(4)) bus ();

  square_wave_gen #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: at each period start, append the whole
  // period's waveform to a queue; one entry per edge.
  bit q[$];
  bit exp_out = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_out = 1'b0;
    end else begin
      if (q.size() == 0) begin
        int r;
        int f;
        r = int'(bus.rise);
        f = int'(bus.fall);
        if (r == 0 && f == 0) q.push_back(1'b0);
        for (int i = 0; i < r; i++) q.push_back(1'b1);
        for (int i = 0; i < f; i++) q.push_back(1'b0);
      end
      exp_out = q.pop_front();
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.rise = 4'd3;
    bus.fall = 4'd4;
    #50;
    total++;
    if (bus.clk_out !== 1'b0)
      $display("FAIL reset: clk_out=%b expected 0",
               bus.clk_out);
    else pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit d;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      d = (((k - 1) % 7) < 3);
      total++;
      if (bus.clk_out !== d)
        $display("FAIL basic edge %0d: clk_out=%b expected %b",
                 k, bus.clk_out, d);
      else pass++;
      total++;
      if (bus.clk_out !== exp_out)
        $display("FAIL basic_model edge %0d: clk_out=%b expected %b",
                 k, bus.clk_out, exp_out);
      else pass++;
    end
  endtask

  task automatic test_mid_change();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (bus.clk_out === 1'b1);
    end
    total++;
    if (!seen) $display("FAIL mid_wait: clk_out=0 expected 1");
    else pass++;
    @(negedge clk);
    bus.rise = 4'd5;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.clk_out !== exp_out)
        $display("FAIL mid_change cyc %0d: clk_out=%b expected %b",
                 k, bus.clk_out, exp_out);
      else pass++;
    end
  endtask

  task automatic test_zero();
    logic [3:0] rr[4] = '{4'd0, 4'd6, 4'd0, 4'd2};
    logic [3:0] ff[4] = '{4'd4, 4'd0, 4'd0, 4'd2};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus.rise = rr[s];
      bus.fall = ff[s];
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        total++;
        if (bus.clk_out !== exp_out)
          $display("FAIL zero r=%0d f=%0d cyc %0d: clk_out=%b expected %b",
                   rr[s], ff[s], k, bus.clk_out, exp_out);
        else pass++;
      end
      if (s < 3) begin
        bit d = (s == 1);
        total++;
        if (bus.clk_out !== d)
          $display("FAIL zero_level r=%0d f=%0d: clk_out=%b expected %b",
                   rr[s], ff[s], bus.clk_out, d);
        else pass++;
      end
    end
  endtask

  task automatic test_extremes();
    logic [3:0] vv[2] = '{4'd1, 4'd15};
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      bus.rise = vv[s];
      bus.fall = vv[s];
      for (int k = 0; k < 75; k++) begin
        @(posedge clk); #1;
        total++;
        if (bus.clk_out !== exp_out)
          $display("FAIL extreme %0d cyc %0d: clk_out=%b expected %b",
                   vv[s], k, bus.clk_out, exp_out);
        else pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    bit d;
    @(negedge clk);
    bus.rise = 4'd2;
    bus.fall = 4'd5;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (bus.clk_out === 1'b1);
    end
    total++;
    if (!seen) $display("FAIL arst_wait: clk_out=0 expected 1");
    else pass++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.clk_out !== 1'b0)
      $display("FAIL arst_immediate: clk_out=%b expected 0",
               bus.clk_out);
    else pass++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.clk_out !== 1'b0)
      $display("FAIL arst_hold: clk_out=%b expected 0",
               bus.clk_out);
    else pass++;
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      d = (((k - 1) % 7) < 2);
      total++;
      if (bus.clk_out !== d)
        $display("FAIL arst_restart edge %0d: clk_out=%b expected %b",
                 k, bus.clk_out, d);
      else pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        bus.rise = 4'($urandom_range(15));
        bus.fall = 4'($urandom_range(15));
        if ($urandom_range(5) == 0) bus.rise = 4'd0;
        if ($urandom_range(5) == 0) bus.fall = 4'd0;
      end
      @(posedge clk); #1;
      total++;
      if (bus.clk_out !== exp_out)
        $display("FAIL random cyc %0d: clk_out=%b expected %b",
                 k, bus.clk_out, exp_out);
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_change();
    test_zero();
    test_extremes();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
